// File: rtl/money_counter.sv
// Deposit-side cash counter: accumulates accepted notes per drawer session
// and reports the session total to the control unit with a one-cycle pulse.
module money_counter #(
    parameter int BALANCE_WIDTH    = 16,
    parameter int MAX_NOTES        = 40,
    parameter int NOTE_COUNT_WIDTH = $clog2(MAX_NOTES + 1),
    parameter int IDLE_TIMEOUT     = 1000,
    parameter int TIMEOUT_WIDTH    = $clog2(IDLE_TIMEOUT)
) (
    input  logic                        clk,
    input  logic                        RST,
    input  logic                        In_Drawer_En,
    input  logic                        In_Drawer_Closed,
    input  logic                        In_Note_Valid,
    input  logic [1:0]                  In_Note_Denom,
    output logic                        Out_Money_Counter_Valid,
    output logic [BALANCE_WIDTH-1:0]    Out_Money_Counter_Amount,
    output logic [NOTE_COUNT_WIDTH-1:0] Out_Note_Count,
    output logic                        Out_Return_Note,
    output logic                        Out_Busy
);

    localparam int VW = BALANCE_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        REPORT,
        WAIT_RELEASE
    } state_t;

    state_t                      state_q, state_d;
    logic [BALANCE_WIDTH-1:0]    amount_q, amount_d;
    logic [NOTE_COUNT_WIDTH-1:0] count_q, count_d;
    logic [TIMEOUT_WIDTH-1:0]    timer_q, timer_d;
    logic                        valid_q, valid_d;
    logic                        ret_q, ret_d;
    logic                        busy_q, busy_d;

    logic [VW-1:0] value;
    logic [VW-1:0] sum;
    logic          reject;
    logic          end_cond;

    always_comb begin
        unique case (In_Note_Denom)
            2'd0:    value = VW'(10);
            2'd1:    value = VW'(20);
            2'd2:    value = VW'(50);
            default: value = VW'(100);
        endcase
    end

    // The extra sum bit catches accumulation past the amount width.
    assign sum      = {1'b0, amount_q} + value;
    assign reject   = (count_q == NOTE_COUNT_WIDTH'(MAX_NOTES)) || sum[BALANCE_WIDTH];
    assign end_cond = !In_Drawer_En || In_Drawer_Closed ||
                      ((timer_q == TIMEOUT_WIDTH'(IDLE_TIMEOUT - 1)) && !In_Note_Valid);

    always_comb begin
        state_d  = state_q;
        amount_d = amount_q;
        count_d  = count_q;
        timer_d  = timer_q;
        ret_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (In_Drawer_En) begin
                    state_d  = COLLECT;
                    amount_d = '0;
                    count_d  = '0;
                    timer_d  = '0;
                end
            end
            COLLECT: begin
                if (In_Note_Valid) begin
                    timer_d = '0;
                    if (reject) begin
                        ret_d = 1'b1;
                    end else begin
                        amount_d = sum[BALANCE_WIDTH-1:0];
                        count_d  = count_q + 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
                if (end_cond) begin
                    state_d = REPORT;
                end
            end
            REPORT: begin
                state_d = In_Drawer_En ? WAIT_RELEASE : IDLE;
            end
            WAIT_RELEASE: begin
                if (!In_Drawer_En) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        valid_d = (state_d == REPORT);
        busy_d  = (state_d == COLLECT) || (state_d == REPORT);
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q  <= IDLE;
            amount_q <= '0;
            count_q  <= '0;
            timer_q  <= '0;
            valid_q  <= 1'b0;
            ret_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            amount_q <= amount_d;
            count_q  <= count_d;
            timer_q  <= timer_d;
            valid_q  <= valid_d;
            ret_q    <= ret_d;
            busy_q   <= busy_d;
        end
    end

    assign Out_Money_Counter_Valid  = valid_q;
    assign Out_Money_Counter_Amount = amount_q;
    assign Out_Note_Count           = count_q;
    assign Out_Return_Note          = ret_q;
    assign Out_Busy                 = busy_q;

endmodule
